jump_redirect_ctrl: RTL and testbench
=====================================

Name: jump_redirect_ctrl

Overview:
- Sequences the decode-stage jump datapath: decides when a resolved jump/jr target may be driven into fetch.
- Stalls F/D while a jr source operand is still being loaded from memory.
- Holds the target across the delay slot and I-cache stalls until fetch accepts it.
- Sits between the decode jump logic and the PC-select mux; yields to exception flushes.

Parameters:
- MAX_WAIT, 3, operand-wait cycles before err_timeout is raised.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- jumpD  in  1  decode holds j/jal/jr/jalr
- jrD  in  1  decode jump is register-sourced (jr/jalr)
- jump_conflictD  in  1  jr source matches a pending writer in E/M/W
- loaduseE  in  1  writer of jr source in E is a load
- loaduseM  in  1  writer of jr source in M is a load not yet returned
- pc_jumpD  in  32  resolved target (immediate, or forwarded rd1D)
- slot_fetchedF  in  1  delay-slot instruction (pcplus4D) is present in F
- inst_stallF  in  1  I-side busy; F cannot accept a new PC this cycle
- stall_ext  in  1  global pipeline stall (D-cache, divider)
- flush_excep  in  1  exception/eret flush
- stallF  out  1  controller-requested fetch stall
- stallD  out  1  controller-requested decode stall
- redirect_valid  out  1  PC mux selects redirect_pc this cycle
- redirect_pc  out  32  jump target
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; operand wait exceeded MAX_WAIT
- stall_cycles  out  CNT_W  cycles spent in OPND, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at a clk edge) state=IDLE. Zeroed: tgt_q, wait_cnt, stall_cycles, err_timeout. All outputs 0.
- States: IDLE, OPND (waiting for jr operand), PEND (target held, fetch not yet accepted).
- Definitions:
  - need_wait = jumpD & jrD & jump_conflictD & (loaduseE | loaduseM).
  - accept = slot_fetchedF & ~inst_stallF.
- IDLE:
  - jumpD & ~stall_ext & need_wait: stallF=stallD=1; next OPND; wait_cnt<=1.
  - jumpD & ~stall_ext & ~need_wait & accept: redirect_valid=1, redirect_pc=pc_jumpD combinationally (zero latency); stay IDLE.
  - jumpD & ~stall_ext & ~need_wait & ~accept: tgt_q<=pc_jumpD; next PEND; redirect_valid=0 this cycle.
  - jumpD & stall_ext: no action; the jump remains in D and is re-evaluated next cycle.
- OPND:
  - stallF=stallD=1 every cycle; stall_cycles increments each cycle.
  - need_wait still 1: wait_cnt increments (saturating); err_timeout<=1 when wait_cnt reaches MAX_WAIT, and the state stays OPND.
  - need_wait==0: same capture/redirect decision as IDLE in this cycle, with stalls deasserted. Result is a redirect, or a move to PEND.
- PEND:
  - redirect_valid=1, redirect_pc=tgt_q; stallF=stallD=0.
  - accept: next IDLE.
  - A new jumpD arriving in PEND is ignored (delay slot cannot be a jump).
- stall_ext in OPND/PEND: state and tgt_q frozen; redirect_valid stays asserted in PEND.
- flush_excep: top priority in any state.
  - That cycle: redirect_valid=stallF=stallD=0.
  - Next state IDLE; tgt_q<=0; wait_cnt<=0.
  - err_timeout and stall_cycles are not cleared.
- Flush and jump in the same cycle: flush wins; the jump is discarded.
- Reset mid-OPND/PEND: IDLE on the next edge; no redirect is emitted.
- Non-load conflicts (ALU result forwarded) never stall: the target from the forwarded rd1D is used directly.

Decomposition:
- Shared package cpu_defs_pkg:
  - jctl_state_t enum {IDLE, OPND, PEND}.
  - PC_W=32.
  - RESET_PC constant, reused by the PC register.
- No sub-module: single always_ff for state/tgt_q/counters, plus one always_comb for outputs.

Test Plan:
- Plain j: jumpD=1, pc_jumpD=0xBFC0_0100, accept=1 -> same cycle redirect_valid=1, redirect_pc=0xBFC0_0100; busy=0.
- jr after load in E: jrD=jump_conflictD=loaduseE=1 for 1 cycle, then loaduseM=1 for 1 cycle, then clear with pc_jumpD=0x8000_0040 -> stallF/stallD high for 2 cycles; redirect to 0x8000_0040 in the 3rd cycle; stall_cycles=2.
- I-cache miss on delay slot: jump with inst_stallF=1 for 4 cycles -> PEND with redirect_pc held at the captured target for all 4 cycles; IDLE after accept.
- Exception during PEND: flush_excep=1 -> that cycle redirect_valid=0, next cycle IDLE, tgt_q=0.
- Timeout: loaduseE held 5 cycles, MAX_WAIT=3 -> err_timeout=1 from the 3rd cycle and remains 1 after the operand arrives.
- stall_ext=1 with jumpD in IDLE for 3 cycles -> no redirect and no state change; redirect on the first cycle stall_ext=0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: PC width, reset vector and jump-redirect controller states.
package cpu_defs_pkg;

   localparam int unsigned PC_W     = 32;
   localparam logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPND = 2'd1,
      PEND = 2'd2
   } jctl_state_t;

endpackage

// File: rtl/jump_redirect_ctrl.sv
// Decode-stage jump sequencer: waits out jr load operands, holds the target until
// fetch accepts it, and gives way to exception flushes.
module jump_redirect_ctrl
   import cpu_defs_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 3,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jumpD,
   input  logic             jrD,
   input  logic             jump_conflictD,
   input  logic             loaduseE,
   input  logic             loaduseM,
   input  logic [PC_W-1:0]  pc_jumpD,
   input  logic             slot_fetchedF,
   input  logic             inst_stallF,
   input  logic             stall_ext,
   input  logic             flush_excep,
   output logic             stallF,
   output logic             stallD,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             busy,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   jctl_state_t       state_q, state_d;
   logic [PC_W-1:0]   tgt_q, tgt_d;
   logic [WAIT_W-1:0] wait_cnt, wait_d;
   logic              err_d;
   logic              need_wait;
   logic              accept;

   // State, captured target and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         tgt_q        <= '0;
         wait_cnt     <= '0;
         err_timeout  <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         wait_cnt    <= wait_d;
         err_timeout <= err_d;
         if (state_q == OPND)
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   // Next state and redirect/stall outputs; reset and flush suppress everything
   always_comb begin
      state_d        = state_q;
      tgt_d          = tgt_q;
      wait_d         = wait_cnt;
      err_d          = err_timeout;
      stallF         = 1'b0;
      stallD         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      need_wait = jumpD & jrD & jump_conflictD & (loaduseE | loaduseM);
      accept    = slot_fetchedF & ~inst_stallF;

      if (rst || flush_excep) begin
         state_d = IDLE;
         tgt_d   = '0;
         wait_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (jumpD && !stall_ext) begin
                  if (need_wait) begin
                     stallF  = 1'b1;
                     stallD  = 1'b1;
                     state_d = OPND;
                     wait_d  = WAIT_ONE;
                     if (WAIT_ONE == WAIT_MAX)
                        err_d = 1'b1;
                  end else if (accept) begin
                     redirect_valid = 1'b1;
                     redirect_pc    = pc_jumpD;
                  end else begin
                     tgt_d   = pc_jumpD;
                     state_d = PEND;
                  end
               end
            end
            OPND: begin
               if (stall_ext) begin
                  stallF = 1'b1;
                  stallD = 1'b1;
               end else if (need_wait) begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  if (wait_cnt != WAIT_MAX)
                     wait_d = wait_cnt + WAIT_ONE;
                  if (wait_d == WAIT_MAX)
                     err_d = 1'b1;
               end else begin
                  // Operand has arrived: resolve exactly as a fresh jump would
                  wait_d = '0;
                  if (accept) begin
                     redirect_valid = 1'b1;
                     redirect_pc    = pc_jumpD;
                     state_d        = IDLE;
                  end else begin
                     tgt_d   = pc_jumpD;
                     state_d = PEND;
                  end
               end
            end
            PEND: begin
               redirect_valid = 1'b1;
               redirect_pc    = tgt_q;
               if (accept && !stall_ext)
                  state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed self-checking bench for jump_redirect_ctrl.
module tb_jump_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        jumpD, jrD, jump_conflictD, loaduseE, loaduseM;
   logic [31:0] pc_jumpD;
   logic        slot_fetchedF, inst_stallF, stall_ext, flush_excep;
   logic        stallF, stallD, redirect_valid, busy, err_timeout;
   logic [31:0] redirect_pc;
   logic [31:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jump_redirect_ctrl #(.MAX_WAIT(3), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .jumpD          (jumpD),
      .jrD            (jrD),
      .jump_conflictD (jump_conflictD),
      .loaduseE       (loaduseE),
      .loaduseM       (loaduseM),
      .pc_jumpD       (pc_jumpD),
      .slot_fetchedF  (slot_fetchedF),
      .inst_stallF    (inst_stallF),
      .stall_ext      (stall_ext),
      .flush_excep    (flush_excep),
      .stallF         (stallF),
      .stallD         (stallD),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .err_timeout    (err_timeout),
      .stall_cycles   (stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      jumpD = 0; jrD = 0; jump_conflictD = 0; loaduseE = 0; loaduseM = 0;
      pc_jumpD = 32'h0; slot_fetchedF = 1; inst_stallF = 0; stall_ext = 0; flush_excep = 0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      tick(); tick();
      rst = 0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rv", 32'(redirect_valid), 32'd0);
      chk("rst_stall", 32'({stallF, stallD}), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_cnt", stall_cycles, 32'd0);
      chk("rst_pc", redirect_pc, 32'd0);

      // plain j, fetch ready: zero-latency redirect
      jumpD = 1; pc_jumpD = 32'hBFC0_0100;
      #1;
      chk("j_rv", 32'(redirect_valid), 32'd1);
      chk("j_pc", redirect_pc, 32'hBFC0_0100);
      chk("j_stall", 32'({stallF, stallD}), 32'd0);
      tick();
      chk("j_busy", 32'(busy), 32'd0);

      // jr behind a load in E then in M
      jrD = 1; jump_conflictD = 1; loaduseE = 1; pc_jumpD = 32'h0;
      #1;
      chk("jr_c1_stall", 32'({stallF, stallD}), 32'd3);
      chk("jr_c1_rv", 32'(redirect_valid), 32'd0);
      tick();
      chk("jr_c2_busy", 32'(busy), 32'd1);
      loaduseE = 0; loaduseM = 1;
      #1;
      chk("jr_c2_stall", 32'({stallF, stallD}), 32'd3);
      tick();
      loaduseM = 0; pc_jumpD = 32'h8000_0040;
      #1;
      chk("jr_c3_stall", 32'({stallF, stallD}), 32'd0);
      chk("jr_c3_rv", 32'(redirect_valid), 32'd1);
      chk("jr_c3_pc", redirect_pc, 32'h8000_0040);
      tick();
      chk("jr_busy", 32'(busy), 32'd0);
      chk("jr_cnt", stall_cycles, 32'd2);
      chk("jr_err", 32'(err_timeout), 32'd0);

      // I-cache miss on the delay slot: target held in PEND
      idle_inputs();
      jumpD = 1; pc_jumpD = 32'h0040_0020; inst_stallF = 1;
      #1;
      chk("ic_cap_rv", 32'(redirect_valid), 32'd0);
      tick();
      jumpD = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            jumpD = 1; pc_jumpD = 32'h1111_2222;
         end else begin
            jumpD = 0; pc_jumpD = 32'h0;
         end
         #1;
         chk($sformatf("ic_hold_rv%0d", i), 32'(redirect_valid), 32'd1);
         chk($sformatf("ic_hold_pc%0d", i), redirect_pc, 32'h0040_0020);
         chk($sformatf("ic_hold_busy%0d", i), 32'(busy), 32'd1);
         tick();
      end
      jumpD = 0;
      // fetch ready but global stall: stay in PEND, keep driving target
      inst_stallF = 0; stall_ext = 1;
      #1;
      chk("ic_ext_rv", 32'(redirect_valid), 32'd1);
      chk("ic_ext_pc", redirect_pc, 32'h0040_0020);
      tick();
      chk("ic_ext_busy", 32'(busy), 32'd1);
      stall_ext = 0;
      #1;
      chk("ic_acc_rv", 32'(redirect_valid), 32'd1);
      tick();
      chk("ic_acc_busy", 32'(busy), 32'd0);

      // exception flush while in PEND
      jumpD = 1; pc_jumpD = 32'h1234_5678; inst_stallF = 1;
      tick();
      jumpD = 0;
      #1;
      chk("fl_pend_rv", 32'(redirect_valid), 32'd1);
      flush_excep = 1;
      #1;
      chk("fl_rv", 32'(redirect_valid), 32'd0);
      chk("fl_stall", 32'({stallF, stallD}), 32'd0);
      tick();
      flush_excep = 0;
      chk("fl_busy", 32'(busy), 32'd0);
      chk("fl_tgt", dut.tgt_q, 32'd0);

      // operand wait exceeds MAX_WAIT=3
      idle_inputs();
      jumpD = 1; jrD = 1; jump_conflictD = 1; loaduseE = 1;
      for (int i = 1; i <= 5; i++) begin
         #1;
         chk($sformatf("to_stall%0d", i), 32'({stallF, stallD}), 32'd3);
         tick();
         chk($sformatf("to_err%0d", i), 32'(err_timeout), (i >= 3) ? 32'd1 : 32'd0);
      end
      loaduseE = 0; pc_jumpD = 32'h8000_0100;
      #1;
      chk("to_rv", 32'(redirect_valid), 32'd1);
      chk("to_pc", redirect_pc, 32'h8000_0100);
      tick();
      chk("to_err_sticky", 32'(err_timeout), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_cnt", stall_cycles, 32'd7);

      // global stall with a jump in IDLE
      idle_inputs();
      jumpD = 1; pc_jumpD = 32'h9000_0000; stall_ext = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("se_rv%0d", i), 32'(redirect_valid), 32'd0);
         tick();
         chk($sformatf("se_busy%0d", i), 32'(busy), 32'd0);
      end
      stall_ext = 0;
      #1;
      chk("se_rel_rv", 32'(redirect_valid), 32'd1);
      chk("se_rel_pc", redirect_pc, 32'h9000_0000);
      tick();

      // flush and jump together: jump discarded
      idle_inputs();
      jumpD = 1; pc_jumpD = 32'hA000_0000; inst_stallF = 1; flush_excep = 1;
      #1;
      chk("fj_rv", 32'(redirect_valid), 32'd0);
      tick();
      idle_inputs();
      chk("fj_busy", 32'(busy), 32'd0);

      // ALU-forwarded jr source never stalls
      jumpD = 1; jrD = 1; jump_conflictD = 1; pc_jumpD = 32'h8000_0200;
      #1;
      chk("alu_stall", 32'({stallF, stallD}), 32'd0);
      chk("alu_rv", 32'(redirect_valid), 32'd1);
      chk("alu_pc", redirect_pc, 32'h8000_0200);
      tick();

      // reset in the middle of PEND
      idle_inputs();
      jumpD = 1; pc_jumpD = 32'h0000_0400; inst_stallF = 1;
      tick();
      jumpD = 0; inst_stallF = 0; rst = 1;
      #1;
      chk("rp_rv", 32'(redirect_valid), 32'd0);
      tick();
      rst = 0;
      #1;
      chk("rp_busy", 32'(busy), 32'd0);
      chk("rp_err", 32'(err_timeout), 32'd0);
      chk("rp_cnt", stall_cycles, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
